// File: rtl/vx_tensor_sequencer.sv
// K-loop sequencer for one 4x4 tensor dot-product unit: it loads an initial
// accumulator, issues one operand slice per step and feeds each D back as C.
module vx_tensor_sequencer #(
  parameter int MAX_K_STEPS = 16,
  parameter int KW          = $clog2(MAX_K_STEPS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [KW-1:0]           cmd_steps_m1,
  input  logic [3:0][3:0][31:0]   cmd_C_tile,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [3:0][1:0][31:0]   op_A_tile,
  input  logic [1:0][3:0][31:0]   op_B_tile,
  output logic                    dpu_valid_in,
  output logic [3:0][1:0][31:0]   dpu_A_tile,
  output logic [1:0][3:0][31:0]   dpu_B_tile,
  output logic [3:0][3:0][31:0]   dpu_C_tile,
  output logic                    dpu_stall,
  input  logic                    dpu_valid_out,
  input  logic [3:0][3:0][31:0]   dpu_D_tile,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [3:0][3:0][31:0]   rsp_D_tile,
  output logic                    busy,
  output logic                    err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0][3:0][31:0] acc_q, acc_d;
  logic [KW-1:0]         cnt_q, cnt_d;
  logic [KW-1:0]         last_q, last_d;
  logic                  err_q, err_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Handshake outputs are masked by reset so nothing is offered while it is held.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    err_d        = err_q;
    cmd_ready    = 1'b0;
    op_ready     = 1'b0;
    dpu_valid_in = 1'b0;
    rsp_valid    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = reset;
        if (cmd_valid) begin
          acc_d   = cmd_C_tile;
          cnt_d   = '0;
          last_d  = cmd_steps_m1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        op_ready     = reset;
        dpu_valid_in = op_valid & reset;
        if (op_valid) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dpu_valid_out) begin
          acc_d = dpu_D_tile;
          if (cnt_q == last_q) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + KW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        rsp_valid = reset;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A DPU result outside WAIT has no owner: flag it and leave acc/state alone.
    if (dpu_valid_out && (state_q != S_WAIT)) err_d = 1'b1;
  end

  assign dpu_A_tile = op_A_tile;
  assign dpu_B_tile = op_B_tile;
  assign dpu_C_tile = acc_q;
  assign dpu_stall  = 1'b0;
  assign rsp_D_tile = acc_q;
  assign busy       = reset && (state_q != S_IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_vx_tensor_sequencer.sv
// Bench for vx_tensor_sequencer with a 3-cycle fp32 DPU model built from real arithmetic.
module tb_vx_tensor_sequencer;
  localparam int KW = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [KW-1:0]         cmd_steps_m1;
  logic [3:0][3:0][31:0] cmd_C_tile;
  logic                  op_valid;
  logic                  op_ready;
  logic [3:0][1:0][31:0] op_A_tile;
  logic [1:0][3:0][31:0] op_B_tile;
  logic                  dpu_valid_in;
  logic [3:0][1:0][31:0] dpu_A_tile;
  logic [1:0][3:0][31:0] dpu_B_tile;
  logic [3:0][3:0][31:0] dpu_C_tile;
  logic                  dpu_stall;
  logic                  dpu_valid_out;
  logic [3:0][3:0][31:0] dpu_D_tile;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [3:0][3:0][31:0] rsp_D_tile;
  logic                  busy;
  logic                  err;

  vx_tensor_sequencer #(.MAX_K_STEPS(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_steps_m1(cmd_steps_m1), .cmd_C_tile(cmd_C_tile),
    .op_valid(op_valid), .op_ready(op_ready), .op_A_tile(op_A_tile), .op_B_tile(op_B_tile),
    .dpu_valid_in(dpu_valid_in), .dpu_A_tile(dpu_A_tile), .dpu_B_tile(dpu_B_tile), .dpu_C_tile(dpu_C_tile),
    .dpu_stall(dpu_stall), .dpu_valid_out(dpu_valid_out), .dpu_D_tile(dpu_D_tile),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_D_tile(rsp_D_tile),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // fp32 <-> real for normal values and zero.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    if (f[30:0] == 31'd0) return 0.0;
    b = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
  endfunction

  function automatic logic [511:0] dpu_fn(input logic [3:0][1:0][31:0] a,
                                          input logic [1:0][3:0][31:0] b,
                                          input logic [3:0][3:0][31:0] c);
    logic [3:0][3:0][31:0] d;
    real s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = f2r(c[i][j]);
        for (int k = 0; k < 2; k++) s = s + f2r(a[i][k]) * f2r(b[k][j]);
        d[i][j] = r2f(s);
      end
    return d;
  endfunction

  // DPU model: 3-cycle latency, cleared by the shared reset, plus a spurious-result injector.
  logic         pv0, pv1, pv2;
  logic [511:0] pd0, pd1, pd2;
  logic         inj_v;
  logic [511:0] inj_d;

  always @(posedge clk) begin
    if (!reset) begin
      pv0 <= 1'b0; pv1 <= 1'b0; pv2 <= 1'b0;
    end else begin
      pv0 <= dpu_valid_in; pv1 <= pv0; pv2 <= pv1;
    end
    pd0 <= dpu_fn(dpu_A_tile, dpu_B_tile, dpu_C_tile);
    pd1 <= pd0;
    pd2 <= pd1;
  end

  assign dpu_valid_out = pv2 | inj_v;
  assign dpu_D_tile    = inj_v ? inj_d : pd2;

  // Cycle, issue and handshake monitor.
  int cyc = 0, t_cmd = 0, issues = 0, op_fires = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) t_cmd <= cyc;
    if (dpu_valid_in) issues <= issues + 1;
    if (op_valid && op_ready) op_fires <= op_fires + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input logic [KW-1:0] sm1, input logic [31:0] cval, input logic [15:0] gaps,
                     input int hold, input bit inj,
                     output int lat, output int iss, output logic [511:0] d);
    int gi, gap, seen, base;
    bit got;
    @(negedge clk);
    cmd_steps_m1 = sm1;
    cmd_C_tile   = {16{cval}};
    cmd_valid    = 1'b1;
    rsp_ready    = (hold == 0);
    gi = 0; gap = int'(gaps[3:0]); op_valid = (gap == 0);
    seen = op_fires; base = issues; got = 0; lat = -1; d = '0;
    for (int to = 0; to < 400 && !got; to++) begin
      @(negedge clk);
      if (busy) cmd_valid = 1'b0;
      if (op_fires != seen) begin
        seen = op_fires; gi++;
        gap = (gi < 4) ? int'(gaps[4*gi +: 4]) : 0;
        op_valid = (gap == 0);
      end else if (!op_valid && op_ready) begin
        if (gap > 0) gap--; else op_valid = 1'b1;
      end
      if (rsp_valid) begin
        lat = cyc - t_cmd;
        d = rsp_D_tile;
        for (int h = 0; h < hold; h++) begin
          if (inj && h == 0) begin inj_v = 1'b1; inj_d = {16{32'hDEADBEEF}}; end
          @(negedge clk);
          inj_v = 1'b0;
          chk("rsp_hold_valid", 512'(rsp_valid), 512'(1));
          chk("rsp_hold_d", rsp_D_tile, d);
          chk("cmd_ready_hold", 512'(cmd_ready), 512'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_rsp", 512'({cmd_ready, rsp_valid, busy}), 512'(3'b100));
        got = 1;
      end
    end
    op_valid  = 1'b0;
    cmd_valid = 1'b0;
    iss = issues - base;
  endtask

  typedef struct {
    logic [KW-1:0] sm1;
    logic [31:0]   cval;
    logic [15:0]   gaps;
    logic [31:0]   exp_d;
    int            exp_lat;
    int            exp_iss;
  } vec_t;

  vec_t tbl[5];
  int lat, iss, base;
  logic [511:0] d;

  initial begin
    // {steps-1, C, per-step op gaps, D element, rsp latency, DPU issues}; L=3.
    tbl[0] = '{4'd3,  32'h00000000, 16'h0000, 32'h41000000, 17, 4};
    tbl[1] = '{4'd0,  32'h3F800000, 16'h0000, 32'h40400000,  5, 1};
    tbl[2] = '{4'd3,  32'h00000000, 16'h1302, 32'h41000000, 23, 4};
    tbl[3] = '{4'd15, 32'h00000000, 16'h0000, 32'h42000000, 65, 16};
    tbl[4] = '{4'd1,  32'h40000000, 16'h0011, 32'h40C00000, 11, 2};

    reset = 1'b0; cmd_valid = 1'b0; cmd_steps_m1 = '0; cmd_C_tile = '0;
    op_valid = 1'b0; rsp_ready = 1'b0; inj_v = 1'b0; inj_d = '0;
    op_A_tile = {8{32'h3F800000}};
    op_B_tile = {8{32'h3F800000}};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 512'({cmd_ready, op_ready, rsp_valid, dpu_valid_in, busy, err}), 512'(0));
    chk("dpu_stall", 512'(dpu_stall), 512'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", 512'({cmd_ready, busy}), 512'(2'b10));

    for (int v = 0; v < 5; v++) begin
      run(tbl[v].sm1, tbl[v].cval, tbl[v].gaps, 0, 1'b0, lat, iss, d);
      chk($sformatf("vec%0d_D", v), d, {16{tbl[v].exp_d}});
      chk($sformatf("vec%0d_latency", v), 512'(lat), 512'(tbl[v].exp_lat));
      chk($sformatf("vec%0d_issues", v), 512'(iss), 512'(tbl[v].exp_iss));
      chk($sformatf("vec%0d_err", v), 512'(err), 512'(0));
    end

    // rsp backpressure for 10 cycles
    run(4'd0, 32'h0, 16'h0, 10, 1'b0, lat, iss, d);
    chk("hold_D", d, {16{32'h40000000}});
    chk("hold_latency", 512'(lat), 512'(5));

    // Reset while step 2 is in WAIT
    @(negedge clk);
    cmd_steps_m1 = 4'd3; cmd_C_tile = '0; cmd_valid = 1'b1; op_valid = 1'b1; rsp_ready = 1'b1;
    base = issues;
    for (int to = 0; to < 100; to++) begin
      @(negedge clk);
      if (busy) cmd_valid = 1'b0;
      if (issues - base == 2 && busy && !op_ready) break;
    end
    chk("midrun_in_wait", 512'({busy, op_ready, issues - base}), 512'({1'b1, 1'b0, 32'd2}));
    reset = 1'b0;
    @(negedge clk);
    chk("midrun_reset_outputs", 512'({cmd_ready, op_ready, rsp_valid, dpu_valid_in, busy, err}), 512'(0));
    reset = 1'b1; op_valid = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 512'({cmd_ready, busy}), 512'(2'b10));
    run(4'd0, 32'h0, 16'h0, 0, 1'b0, lat, iss, d);
    chk("post_reset_D", d, {16{32'h40000000}});
    chk("post_reset_latency", 512'(lat), 512'(5));
    chk("post_reset_err", 512'(err), 512'(0));

    // Spurious DPU result in IDLE, then in DONE
    @(negedge clk);
    inj_v = 1'b1; inj_d = {16{32'h12345678}};
    @(negedge clk);
    inj_v = 1'b0;
    chk("spurious_idle", 512'({err, busy, cmd_ready}), 512'(3'b101));
    run(4'd1, 32'h3F800000, 16'h0, 3, 1'b1, lat, iss, d);
    chk("spurious_D", d, {16{32'h40A00000}});
    chk("spurious_issues", 512'(iss), 512'(2));
    chk("err_sticky", 512'(err), 512'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
